// File: rtl/stb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stb_pkg
// Description : Shared types and constants for the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package stb_pkg;

    localparam int STB_ADDR_W = 32;
    localparam int STB_DATA_W = 32;

    // Forwarding mux inputs beyond the per-entry data inputs.
    localparam logic [4:0] SEL_CACHE = 5'd16;
    localparam logic [4:0] SEL_NONE  = 5'd17;

    typedef struct packed {
        logic                      valid;
        logic [STB_ADDR_W-1:0]     addr;
        logic [STB_DATA_W-1:0]     data;
        logic [STB_DATA_W/8-1:0]   mbe;
    } stb_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drain_state_t;

endpackage : stb_pkg
`default_nettype wire

// File: rtl/stb_match.sv
`default_nettype none
// ============================================================================
// Module      : stb_match
// Description : Youngest-first word match search over the store buffer entries.
// Revision    : 1.0 - initial release
// ============================================================================
module stb_match
    import stb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WA_W  = 30,
    parameter int BE_W  = 4,
    parameter int PTR_W = 4
) (
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH*WA_W-1:0]  addr,
    input  logic [DEPTH*BE_W-1:0]  mbe,
    input  logic [PTR_W-1:0]       tail,
    input  logic [WA_W-1:0]        ld_word,
    input  logic [BE_W-1:0]        ld_mbe,
    output logic                   hit,
    output logic                   full_cover,
    output logic [PTR_W-1:0]       index
);

    logic [DEPTH-1:0] w_match;
    logic [DEPTH-1:0] w_rot;
    logic [PTR_W-1:0] w_off;
    logic [BE_W-1:0]  w_hit_mbe;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = valid[i] && (addr[i*WA_W +: WA_W] == ld_word)
                         && (|(mbe[i*BE_W +: BE_W] & ld_mbe));
        end
    end

    // After rotation bit j refers to entry tail+j, so bit DEPTH-1 is the youngest.
    for (genvar j = 0; j < DEPTH; j++) begin : g_rot
        assign w_rot[j] = w_match[tail + PTR_W'(j)];
    end

    always_comb begin
        w_off = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (w_rot[j]) begin
                w_off = PTR_W'(j);
            end
        end
    end

    assign hit        = |w_rot;
    assign index      = tail + w_off;
    assign w_hit_mbe  = mbe[index*BE_W +: BE_W];
    assign full_cover = ((w_hit_mbe & ld_mbe) == ld_mbe);

endmodule : stb_match
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : 16-entry FIFO store buffer draining to the D-cache, with load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  logic [DATA_W/8-1:0]     st_mbe,
    output logic                    st_ready,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_byte_enable,
    input  logic                    mem_resp,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [DATA_W/8-1:0]     ld_mbe,
    output logic [4:0]              fwd_sel,
    output logic                    fwd_stall,
    output logic [DEPTH*DATA_W-1:0] ent_data,
    output logic                    empty
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;
    logic [DEPTH-1:0]        r_valid;
    logic [DEPTH*WA_W-1:0]   r_addr;
    logic [DEPTH*DATA_W-1:0] r_data;
    logic [DEPTH*BE_W-1:0]   r_mbe;
    drain_state_t            r_state;

    drain_state_t            w_state_next;
    logic [CNT_W-1:0]        w_count_next;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_hit;
    logic                    w_full_cover;
    logic [PTR_W-1:0]        w_idx;
    logic                    w_unused_lowbits;

    // Entries store word addresses only; the byte offset never matters.
    assign w_unused_lowbits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready = (r_count != c_full);
    assign empty    = (r_count == '0);
    assign w_push   = st_valid && st_ready;
    assign w_pop    = (r_state == WRITE) && mem_resp;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        mem_write    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                if (w_pop && (w_count_next == '0)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign mem_address     = {r_addr[r_head*WA_W +: WA_W], 2'b00};
    assign mem_wdata       = r_data[r_head*DATA_W +: DATA_W];
    assign mem_byte_enable = r_mbe[r_head*BE_W +: BE_W];
    assign ent_data        = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_tail          <= r_tail + PTR_W'(1);
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + PTR_W'(1);
                r_valid[r_head] <= 1'b0;
            end
        end
    end

    // Payload is deliberately not reset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail*WA_W +: WA_W]     <= st_addr[ADDR_W-1:2];
            r_data[r_tail*DATA_W +: DATA_W] <= st_data;
            r_mbe[r_tail*BE_W +: BE_W]      <= st_mbe;
        end
    end

    stb_match #(
        .DEPTH (DEPTH),
        .WA_W  (WA_W),
        .BE_W  (BE_W),
        .PTR_W (PTR_W)
    ) u_match (
        .valid      (r_valid),
        .addr       (r_addr),
        .mbe        (r_mbe),
        .tail       (r_tail),
        .ld_word    (ld_addr[ADDR_W-1:2]),
        .ld_mbe     (ld_mbe),
        .hit        (w_hit),
        .full_cover (w_full_cover),
        .index      (w_idx)
    );

    always_comb begin
        fwd_sel   = SEL_NONE;
        fwd_stall = 1'b0;
        if (ld_valid) begin
            if (!w_hit) begin
                fwd_sel = SEL_CACHE;
            end else if (w_full_cover) begin
                fwd_sel = 5'(w_idx);
            end else begin
                fwd_sel   = SEL_CACHE;
                fwd_stall = 1'b1;
            end
        end
    end

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic         clk;
    logic         rst;
    logic         st_valid;
    logic [31:0]  st_addr;
    logic [31:0]  st_data;
    logic [3:0]   st_mbe;
    logic         st_ready;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic         mem_resp;
    logic         ld_valid;
    logic [31:0]  ld_addr;
    logic [3:0]   ld_mbe;
    logic [4:0]   fwd_sel;
    logic         fwd_stall;
    logic [511:0] ent_data;
    logic         empty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mbe;
        int          slot;
    } ent_t;

    ent_t q[$];
    int   m_tail    = 0;
    bit   m_writing = 0;

    store_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .st_valid        (st_valid),
        .st_addr         (st_addr),
        .st_data         (st_data),
        .st_mbe          (st_mbe),
        .st_ready        (st_ready),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .ld_valid        (ld_valid),
        .ld_addr         (ld_addr),
        .ld_mbe          (ld_mbe),
        .fwd_sel         (fwd_sel),
        .fwd_stall       (fwd_stall),
        .ent_data        (ent_data),
        .empty           (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: FIFO of committed stores plus a "write in flight" flag.
    task automatic tick();
        bit push;
        bit pop;
        int sz;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_tail    = 0;
            m_writing = 0;
        end else begin
            sz   = q.size();
            push = st_valid && (sz != 16);
            pop  = m_writing && mem_resp;
            if (pop) q.delete(0);
            if (push) begin
                q.push_back('{st_addr, st_data, st_mbe, m_tail});
                m_tail = (m_tail + 1) % 16;
            end
            if (m_writing) m_writing = pop ? (q.size() != 0) : 1'b1;
            else           m_writing = (sz != 0);
        end
        #1;
    endtask

    task automatic exp_fwd(output logic [4:0] sel, output logic stall);
        sel   = 5'd17;
        stall = 1'b0;
        if (ld_valid) begin
            sel = 5'd16;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr[31:2] == ld_addr[31:2] && (q[i].mbe & ld_mbe) != 4'h0) begin
                    if ((q[i].mbe & ld_mbe) == ld_mbe) sel = 5'(q[i].slot);
                    else stall = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic set_st(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_mbe   = be;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_st(0, 0, 0, 0);
        mem_resp = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_mbe   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL reset_st_ready got=%0b exp=1", st_ready); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%0b exp=0", mem_write); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        total++; if (fwd_sel !== 5'd17 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL reset_fwd got=%0d/%0b exp=17/0", fwd_sel, fwd_stall); end
        ld_valid = 1'b1; ld_addr = 32'h100; ld_mbe = 4'hF;
        #1;
        total++; if (fwd_sel !== 5'd16) begin bad++; $display("FAIL reset_probe got=%0d exp=16", fwd_sel); end
        ld_valid = 1'b0;
    endtask

    task automatic test_drain_basic();
        do_reset();
        set_st(1, 32'h103, 32'hDEADBEEF, 4'hF);
        tick();
        set_st(0, 0, 0, 0);
        #1;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL drain_early got=%0b exp=0", mem_write); end
        tick();
        ld_valid = 1'b1; ld_addr = 32'h100; ld_mbe = 4'hF;
        #1;
        total++; if (mem_write !== 1'b1 || mem_address !== 32'h100 || mem_wdata !== 32'hDEADBEEF || mem_byte_enable !== 4'hF)
            begin bad++; $display("FAIL drain_req got=%0b %h %h %h exp=1 00000100 deadbeef f", mem_write, mem_address, mem_wdata, mem_byte_enable); end
        total++; if (fwd_sel !== 5'd0) begin bad++; $display("FAIL drain_head_fwd got=%0d exp=0", fwd_sel); end
        tick();
        #1;
        total++; if (mem_write !== 1'b1 || mem_address !== 32'h100)
            begin bad++; $display("FAIL drain_hold got=%0b %h exp=1 00000100", mem_write, mem_address); end
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        #1;
        total++; if (empty !== 1'b1 || mem_write !== 1'b0 || fwd_sel !== 5'd16)
            begin bad++; $display("FAIL drain_done got=%0b %0b %0d exp=1 0 16", empty, mem_write, fwd_sel); end
        ld_valid = 1'b0;
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_st(1, 32'h1000 + 32'(4*i), 32'h1000_0000 + 32'(i), 4'hF);
            tick();
        end
        set_st(1, 32'h2000, 32'h0000_0BAD, 4'hF);
        #1;
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", st_ready); end
        tick();
        set_st(0, 0, 0, 0);
        #1;
        total++; if (dut.r_count !== 5'd16 || ent_data[31:0] !== 32'h1000_0000)
            begin bad++; $display("FAIL full_ignore got=%0d %h exp=16 10000000", dut.r_count, ent_data[31:0]); end
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        set_st(1, 32'h3000, 32'hA5A5A5A5, 4'hF);
        tick();
        set_st(0, 0, 0, 0);
        #1;
        total++; if (ent_data[31:0] !== 32'hA5A5A5A5 || dut.r_count !== 5'd16 || st_ready !== 1'b0)
            begin bad++; $display("FAIL wrap got=%h %0d %0b exp=a5a5a5a5 16 0", ent_data[31:0], dut.r_count, st_ready); end
        // full: simultaneous store and pop must reject the store
        set_st(1, 32'h4000, 32'h0000_0077, 4'hF);
        mem_resp = 1'b1;
        tick();
        set_st(0, 0, 0, 0);
        mem_resp = 1'b0;
        #1;
        total++; if (dut.r_count !== 5'd15 || ent_data[63:32] !== 32'h1000_0001 || mem_address !== 32'h1008 || st_ready !== 1'b1)
            begin bad++; $display("FAIL full_pushpop got=%0d %h %h %0b exp=15 10000001 00001008 1", dut.r_count, ent_data[63:32], mem_address, st_ready); end
    endtask

    task automatic test_mid_push_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_st(1, 32'h500 + 32'(4*i), 32'h50 + 32'(i), 4'hF);
            tick();
        end
        set_st(0, 0, 0, 0);
        for (int k = 0; k < 5 && mem_write !== 1'b1; k++) tick();
        total++; if (mem_write !== 1'b1 || mem_address !== 32'h500)
            begin bad++; $display("FAIL mid_wait got=%0b %h exp=1 00000500", mem_write, mem_address); end
        set_st(1, 32'h600, 32'h66, 4'hF);
        mem_resp = 1'b1;
        tick();
        set_st(0, 0, 0, 0);
        mem_resp = 1'b0;
        #1;
        total++; if (dut.r_count !== 5'd5 || dut.r_head !== 4'd1 || dut.r_tail !== 4'd6)
            begin bad++; $display("FAIL mid_ptrs got=%0d %0d %0d exp=5 1 6", dut.r_count, dut.r_head, dut.r_tail); end
        total++; if (mem_address !== 32'h504 || ent_data[5*32 +: 32] !== 32'h66 || mem_write !== 1'b1)
            begin bad++; $display("FAIL mid_data got=%h %h %0b exp=00000504 00000066 1", mem_address, ent_data[5*32 +: 32], mem_write); end
    endtask

    task automatic test_forward();
        do_reset();
        set_st(1, 32'h200, 32'h11111111, 4'hF); tick();
        set_st(1, 32'h200, 32'h22222222, 4'hF); tick();
        ld_valid = 1'b1; ld_addr = 32'h200; ld_mbe = 4'hF;
        set_st(1, 32'h200, 32'h33333333, 4'hF);
        #1;
        total++; if (fwd_sel !== 5'd1 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL fwd_youngest got=%0d/%0b exp=1/0", fwd_sel, fwd_stall); end
        tick();
        set_st(1, 32'h300, 32'h0000ABCD, 4'h3);
        #1;
        total++; if (fwd_sel !== 5'd2) begin bad++; $display("FAIL fwd_visible got=%0d exp=2", fwd_sel); end
        tick();
        set_st(0, 0, 0, 0);
        ld_addr = 32'h300; ld_mbe = 4'hF;
        #1;
        total++; if (fwd_sel !== 5'd16 || fwd_stall !== 1'b1)
            begin bad++; $display("FAIL fwd_partial got=%0d/%0b exp=16/1", fwd_sel, fwd_stall); end
        ld_addr = 32'h302; ld_mbe = 4'h2;
        #1;
        total++; if (fwd_sel !== 5'd3 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL fwd_cover got=%0d/%0b exp=3/0", fwd_sel, fwd_stall); end
        ld_addr = 32'h304; ld_mbe = 4'hF;
        #1;
        total++; if (fwd_sel !== 5'd16 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL fwd_miss got=%0d/%0b exp=16/0", fwd_sel, fwd_stall); end
        ld_valid = 1'b0;
        #1;
        total++; if (fwd_sel !== 5'd17 || fwd_stall !== 1'b0)
            begin bad++; $display("FAIL fwd_idle got=%0d/%0b exp=17/0", fwd_sel, fwd_stall); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_st(1, 32'h700 + 32'(4*i), 32'h70 + 32'(i), 4'hF);
            tick();
        end
        set_st(0, 0, 0, 0);
        for (int k = 0; k < 5 && mem_write !== 1'b1; k++) tick();
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstw_wait got=%0b exp=1", mem_write); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (mem_write !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1)
            begin bad++; $display("FAIL rstw_state got=%0b %0b %0b exp=0 1 1", mem_write, empty, st_ready); end
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        #1;
        total++; if (dut.r_count !== 5'd0 || empty !== 1'b1 || mem_write !== 1'b0)
            begin bad++; $display("FAIL rstw_late_resp got=%0d %0b %0b exp=0 1 0", dut.r_count, empty, mem_write); end
    endtask

    task automatic test_random();
        logic [4:0] e_sel;
        logic       e_stall;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            set_st($urandom_range(0, 9) < 6, 32'h400 + 32'(4*$urandom_range(0, 2)) + 32'($urandom_range(0, 3)),
                   $urandom, 4'($urandom_range(0, 15)));
            mem_resp = ($urandom_range(0, 9) < 3);
            ld_valid = ($urandom_range(0, 9) < 8);
            ld_addr  = 32'h400 + 32'(4*$urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            ld_mbe   = 4'($urandom_range(0, 15));
            #1;
            exp_fwd(e_sel, e_stall);
            total++; if (st_ready !== (q.size() != 16) || empty !== (q.size() == 0) || mem_write !== m_writing)
                begin bad++; $display("FAIL rnd_status c=%0d got=%0b%0b%0b exp=%0b%0b%0b", c, st_ready, empty, mem_write,
                                      q.size() != 16, q.size() == 0, m_writing); end
            if (m_writing) begin
                total++; if (mem_address !== {q[0].addr[31:2], 2'b00} || mem_wdata !== q[0].data || mem_byte_enable !== q[0].mbe)
                    begin bad++; $display("FAIL rnd_head c=%0d got=%h %h %h exp=%h %h %h", c, mem_address, mem_wdata, mem_byte_enable,
                                          {q[0].addr[31:2], 2'b00}, q[0].data, q[0].mbe); end
            end
            total++; if (fwd_sel !== e_sel || fwd_stall !== e_stall)
                begin bad++; $display("FAIL rnd_fwd c=%0d got=%0d/%0b exp=%0d/%0b", c, fwd_sel, fwd_stall, e_sel, e_stall); end
            if (q.size() != 0) begin
                total++; if (ent_data[q[$].slot*32 +: 32] !== q[$].data)
                    begin bad++; $display("FAIL rnd_ent c=%0d got=%h exp=%h", c, ent_data[q[$].slot*32 +: 32], q[$].data); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_drain_basic();
        test_fill_wrap();
        test_mid_push_pop();
        test_forward();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_store_buffer
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store buffer between the MEM stage and the data cache write port.
- Accepts committed stores in program order, holds up to DEPTH of them in a circular FIFO, and drains them oldest-first to the cache through a request/response handshake.
- Services load probes combinationally and produces the 5-bit select that drives the downstream 18-input forwarding mux.
  - Inputs 0..15 of that mux: entry data.
  - Input 16: cache read data.
  - Input 17: zero/idle.

Parameters:
DEPTH, 16, number of entries; fixed at 16 so entry indices map 1:1 onto mux inputs 0..15
ADDR_W, 32, address width
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
st_valid  input  1  store enqueue request
st_addr  input  ADDR_W  store byte address; bits [1:0] ignored
st_data  input  DATA_W  store data, lane-aligned
st_mbe  input  DATA_W/8  store byte enables
st_ready  output  1  buffer can accept a store this cycle
mem_write  output  1  drain write request to cache
mem_address  output  ADDR_W  {head addr[ADDR_W-1:2], 2'b00}
mem_wdata  output  DATA_W  head entry data
mem_byte_enable  output  DATA_W/8  head entry byte enables
mem_resp  input  1  cache write complete
ld_valid  input  1  load probe valid
ld_addr  input  ADDR_W  load byte address
ld_mbe  input  DATA_W/8  bytes the load needs
fwd_sel  output  5  select for the forwarding mux
fwd_stall  output  1  partial-overlap hazard; load must wait
ent_data  output  DEPTH*DATA_W  flattened entry data; entry i at [i*DATA_W +: DATA_W]
empty  output  1  no valid entries, used by fence logic

Behaviour:
- State: head[3:0], tail[3:0], count[4:0], per-entry valid/addr/data/mbe, drain FSM {IDLE, WRITE}.
- Reset (rst=1 at posedge): head=tail=count=0, all valid=0, FSM=IDLE.
  - Resulting outputs: st_ready=1, mem_write=0, empty=1, fwd_sel=17, fwd_stall=0.
  - Entry data/addr are not cleared.
- Reset mid-WRITE:
  - mem_write drops in the cycle after the reset edge.
  - All pending stores are discarded.
  - A mem_resp arriving after reset is ignored.
- Enqueue: st_ready = (count != DEPTH), from registered count.
  - On st_valid && st_ready: write entry[tail], valid=1, tail = tail+1 mod 16, count+1.
  - No same-cycle enqueue when full, even if a pop occurs that cycle.
- Drain FSM:
  - IDLE: if count != 0, go to WRITE next cycle.
  - WRITE: mem_write=1 and drive head entry fields, all stable until mem_resp.
  - On mem_resp in WRITE: clear valid[head], head = head+1 mod 16, count-1. Stay in WRITE if the post-pop count != 0, else go to IDLE.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Wrap-around: pointers are 4-bit and wrap naturally; full vs empty is decided by count, never by pointer equality.
- Load probe is pure combinational, zero latency. Word match means valid && addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2] && (mbe & ld_mbe) != 0.
  - ld_valid=0: fwd_sel=17, fwd_stall=0.
  - No match: fwd_sel=16, fwd_stall=0.
  - Youngest matching entry (search from tail-1 backward toward head) has (mbe & ld_mbe) == ld_mbe: fwd_sel = that entry index, fwd_stall=0.
  - Youngest match covers ld_mbe only partially: fwd_sel=16, fwd_stall=1.
  - Entries older than the youngest match are not merged.
- An entry being enqueued in the same cycle is not visible to the probe; visibility starts the next cycle.
- The head entry in WRITE remains forwardable until the cycle its mem_resp is accepted.
- empty = (count == 0).

Decomposition:
- Package stb_pkg:
  - SEL_CACHE=5'd16, SEL_NONE=5'd17.
  - stb_entry_t struct {valid, addr, data, mbe}.
  - drain_state_t enum {IDLE, WRITE}.
- Sub-module stb_match:
  - Inputs: valid/addr/mbe vectors, tail, ld_addr, ld_mbe.
  - Outputs: hit, full_cover, index.
  - Finds the youngest match by rotating the match vector by tail and priority-encoding.

Test Plan:
- Reset, then enqueue addr 0x100 data 0xDEADBEEF mbe 4'hF → mem_write=1 two cycles after enqueue with mem_address=0x100, mem_wdata=0xDEADBEEF; after mem_resp, empty=1.
- Hold mem_resp=0 and enqueue 16 stores → st_ready=0 after the 16th. A 17th st_valid is ignored. Pop, then enqueue → the new entry lands at index 0 (wrap) and count=16.
- Two stores to 0x200 (0x11111111, then 0x22222222) plus a load to 0x200 mbe 4'hF → fwd_sel equals the index of the second store, fwd_stall=0.
- Store 0x300 mbe 4'h3, then load 0x300 mbe 4'hF → fwd_sel=16, fwd_stall=1. Load 0x304 → fwd_sel=16, fwd_stall=0. ld_valid=0 → fwd_sel=17.
- Full buffer, enqueue and mem_resp in the same cycle → the store is rejected and count=15. With count=5, the same stimulus gives count=5 and head and tail both advance.
- Assert rst during WRITE with 3 entries → next cycle mem_write=0, empty=1, st_ready=1. A late mem_resp leaves count=0.
